// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// Shared definitions for the 10GBASE-R RX link controller: the controller
// state encoding (also decoded by management/status logic) and a sizing helper.
package eth_phy_10g_rx_link_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_SERDES_RST  = 2'd0,
      ST_WAIT_LOCK   = 2'd1,
      ST_WAIT_STABLE = 2'd2,
      ST_LINK_UP     = 2'd3
   } link_state_e;

   // Largest of three timing parameters; sizes the shared state timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module eth_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   // Count events, hold at all-ones, clear on request.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10GBASE-R RX link bring-up controller: sequences SERDES/PCS resets, waits
// for block lock, debounces rx_status into link_up, and keeps event counters.
module eth_phy_10g_rx_link_ctrl
   import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
   parameter int SERDES_RST_CYCLES = 64,
   parameter int LOCK_TIMEOUT      = 2_000_000,
   parameter int LINK_UP_DELAY     = 1024,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 link_enable,
   input  logic                 rx_block_lock,
   input  logic                 rx_high_ber,
   input  logic                 rx_status,
   input  logic                 rx_bad_block,
   input  logic                 serdes_rx_reset_req,
   input  logic                 clr_counters,
   output logic                 serdes_rx_rst,
   output logic                 phy_rx_rst,
   output logic                 link_up,
   output logic [1:0]           ctrl_state,
   output logic [CNT_WIDTH-1:0] bad_block_count,
   output logic [CNT_WIDTH-1:0] link_down_count,
   output logic [CNT_WIDTH-1:0] lock_timeout_count
);

   // The timer only ever reaches (parameter - 1), so $clog2 of the largest
   // parameter is always wide enough and the equality compares never wrap.
   localparam int TIMER_MAX = max3(SERDES_RST_CYCLES, LOCK_TIMEOUT, LINK_UP_DELAY);
   localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

   localparam logic [TW-1:0] SRC_LAST = TW'(SERDES_RST_CYCLES - 1);
   localparam logic [TW-1:0] LT_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] LUD_LAST = TW'(LINK_UP_DELAY - 1);

   link_state_e   r_state;
   link_state_e   w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic          w_lock_to_inc;
   logic          w_link_down_inc;
   logic          w_bad_inc;
   logic          w_override;
   logic          r_serdes_rx_rst;
   logic          r_phy_rx_rst;
   logic          r_link_up;

   assign w_override = !link_enable ||
                       (serdes_rx_reset_req && (r_state != ST_SERDES_RST));

   // Next-state, timer and counter-event decode; overrides applied last so they win.
   // NOTE: every signal gets a default at the top so no path can infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_timer_nxt     = r_timer;
      w_lock_to_inc   = 1'b0;
      w_link_down_inc = 1'b0;
      case (r_state)
         ST_SERDES_RST: begin
            if (link_enable) begin
               if (r_timer == SRC_LAST) w_state_nxt = ST_WAIT_LOCK;
               else                     w_timer_nxt = r_timer + TW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (rx_block_lock) begin
               w_state_nxt = ST_WAIT_STABLE;
            end else if (r_timer == LT_LAST) begin
               w_state_nxt   = ST_SERDES_RST;
               w_lock_to_inc = 1'b1;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         ST_WAIT_STABLE: begin
            if (!rx_block_lock)          w_state_nxt = ST_WAIT_LOCK;
            else if (!rx_status)         w_timer_nxt = '0;
            else if (r_timer == LUD_LAST) w_state_nxt = ST_LINK_UP;
            else                         w_timer_nxt = r_timer + TW'(1);
         end
         ST_LINK_UP: begin
            if (!rx_block_lock || rx_high_ber) begin
               w_state_nxt     = ST_WAIT_LOCK;
               w_link_down_inc = 1'b1;
            end
         end
         default: w_state_nxt = ST_SERDES_RST;
      endcase
      if (w_override) begin
         w_state_nxt     = ST_SERDES_RST;
         w_lock_to_inc   = 1'b0;
         w_link_down_inc = (r_state == ST_LINK_UP);
      end
      if (w_state_nxt != r_state) w_timer_nxt = '0;
   end

   // State and timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SERDES_RST;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Registered output decode, computed from next state so it tracks r_state glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_serdes_rx_rst <= 1'b1;
         r_phy_rx_rst    <= 1'b1;
         r_link_up       <= 1'b0;
      end else begin
         r_serdes_rx_rst <= (w_state_nxt == ST_SERDES_RST);
         r_phy_rx_rst    <= (w_state_nxt == ST_SERDES_RST);
         r_link_up       <= (w_state_nxt == ST_LINK_UP);
      end
   end

   assign w_bad_inc     = rx_bad_block && (r_state == ST_LINK_UP);
   assign serdes_rx_rst = r_serdes_rx_rst;
   assign phy_rx_rst    = r_phy_rx_rst;
   assign link_up       = r_link_up;
   assign ctrl_state    = r_state;

   eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_block_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_bad_inc),
      .clr   (clr_counters),
      .count (bad_block_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_link_down_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_link_down_inc),
      .clr   (clr_counters),
      .count (link_down_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_lock_timeout_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_lock_to_inc),
      .clr   (clr_counters),
      .count (lock_timeout_count)
   );

endmodule
